// File: rtl/simple_spi_slave_pkg.sv
// Shared definitions for the SPI slave: FSM state encoding, byte width and
// the fill byte that is shifted out when no transmit data is available.
package simple_spi_slave_pkg;

    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] IDLE_FILL = 8'hFF;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/spi_slave_fifo.sv
// Receive FIFO for the SPI slave. Extra pointer bit distinguishes full from
// empty. A push into a full FIFO is accepted when a pop happens in the same
// cycle, because the pop frees the slot the push needs.
module spi_slave_fifo
    import simple_spi_slave_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = BYTE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rptr[AW-1:0]];

    // Pointer bookkeeping; the only state that needs a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/simple_spi_slave.sv
// SPI slave with RX FIFO and optional TX path.
// Optional transmit path enabled by defining SIMPLE_SPI_SLAVE_TX_EN; without
// it miso_o, tx_ready_o and tx_underrun_o are held at 0 and the TX inputs
// are ignored.
module simple_spi_slave
    import simple_spi_slave_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CPOL       = 0,
    parameter int CPHA       = 0
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              sck_i,
    input  logic              ss_n_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic [BYTE_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    input  logic [BYTE_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    input  logic              clr_i,
    output logic              busy_o,
    output logic              rx_overrun_o,
    output logic              tx_underrun_o,
    output logic              frame_err_o
);

    localparam logic SCK_IDLE       = (CPOL != 0);
    // Leading edge is rising when CPOL=0; sampling on leading edge when CPHA=0.
    localparam logic SAMPLE_ON_RISE = ((CPOL != 0) == (CPHA != 0));

    logic sck_p0, sck_p1, sck_p2;
    logic ss_p0, ss_p1, ss_p2;
    logic mosi_p0, mosi_p1;

    state_t            state;
    logic [2:0]        cnt;
    logic [BYTE_W-1:0] shreg;
    logic              push_pend;

    logic sck_rise, sck_fall, sample_edge, shift_edge;
    logic ss_fall, ss_rise;
    logic enter, in_frame, byte_done, ferr_set, ovr_set;
    logic fifo_full, fifo_empty, pop;

    // Two-flop synchronizers plus one delayed copy of sck/ss for edge detection.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sck_p0  <= SCK_IDLE;
            sck_p1  <= SCK_IDLE;
            sck_p2  <= SCK_IDLE;
            ss_p0   <= 1'b1;
            ss_p1   <= 1'b1;
            ss_p2   <= 1'b1;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            sck_p0  <= sck_i;
            sck_p1  <= sck_p0;
            sck_p2  <= sck_p1;
            ss_p0   <= ss_n_i;
            ss_p1   <= ss_p0;
            ss_p2   <= ss_p1;
            mosi_p0 <= mosi_i;
            mosi_p1 <= mosi_p0;
        end
    end

    assign sck_rise    = sck_p1 & ~sck_p2;
    assign sck_fall    = ~sck_p1 & sck_p2;
    assign sample_edge = SAMPLE_ON_RISE ? sck_rise : sck_fall;
    assign shift_edge  = SAMPLE_ON_RISE ? sck_fall : sck_rise;
    assign ss_fall     = ~ss_p1 & ss_p2;
    assign ss_rise     = ss_p1 & ~ss_p2;

    // Frame end has priority over a coincident sck edge.
    assign enter     = (state == ST_IDLE) && ss_fall;
    assign in_frame  = (state == ST_SHIFT) && !ss_rise;
    assign byte_done = in_frame && sample_edge && (cnt == 3'd7);
    assign ferr_set  = (state == ST_SHIFT) && ss_rise && (cnt != 3'd0);
    assign pop       = rx_ready_i & ~fifo_empty;
    assign ovr_set   = push_pend & fifo_full & ~pop;
    assign busy_o    = (state == ST_SHIFT);

    // Frame FSM, bit counter and the one-cycle-late FIFO push request.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state     <= ST_IDLE;
            cnt       <= 3'd0;
            push_pend <= 1'b0;
        end else begin
            push_pend <= byte_done;
            if (enter) begin
                state <= ST_SHIFT;
                cnt   <= 3'd0;
            end else if (state == ST_SHIFT && ss_rise) begin
                state <= ST_IDLE;
            end else if (in_frame && sample_edge) begin
                cnt <= cnt + 3'd1;
            end
        end
    end

    // Receive shift register; holds the assembled byte until the push cycle.
    always_ff @(posedge clk_i) begin
        if (in_frame && sample_edge) shreg <= {shreg[BYTE_W-2:0], mosi_p1};
    end

    // Sticky receive-side error flags; a new event wins over clear.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_overrun_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            rx_overrun_o <= ovr_set  | (rx_overrun_o & ~clr_i);
            frame_err_o  <= ferr_set | (frame_err_o  & ~clr_i);
        end
    end

    spi_slave_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk       (clk_i),
        .rst_n     (rstn_i),
        .push      (push_pend),
        .push_data (shreg),
        .pop       (pop),
        .head      (rx_data_o),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rx_valid_o = ~fifo_empty;

`ifdef SIMPLE_SPI_SLAVE_TX_EN
    logic [BYTE_W-1:0] tx_sh;
    logic              tx_load;
    logic              tx_shift;

    // The first bit of each byte is already on miso after a load, so the
    // non-sample edge at count 0 must not shift it away.
    assign tx_load  = enter | byte_done;
    assign tx_shift = in_frame && shift_edge && (cnt != 3'd0);
    assign miso_o   = tx_sh[BYTE_W-1];

    // Transmit holding register, ready handshake and underrun flag.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tx_sh         <= '0;
            tx_ready_o    <= 1'b0;
            tx_underrun_o <= 1'b0;
        end else begin
            tx_ready_o    <= tx_load & tx_valid_i;
            tx_underrun_o <= (tx_load & ~tx_valid_i) | (tx_underrun_o & ~clr_i);
            if (tx_load) begin
                tx_sh <= tx_valid_i ? tx_data_i : IDLE_FILL;
            end else if (tx_shift) begin
                tx_sh <= {tx_sh[BYTE_W-2:0], 1'b0};
            end
        end
    end
`else
    logic unused_tx;

    assign unused_tx     = ^{tx_data_i, tx_valid_i};
    assign miso_o        = 1'b0;
    assign tx_ready_o    = 1'b0;
    assign tx_underrun_o = 1'b0;
`endif

endmodule
